// File: rtl/sb_pkg.sv
// Shared types for the multi-issue register scoreboard: entry layout,
// register address type and functional-unit encodings.
package sb_pkg;

  localparam int SB_DEPTH    = 3;
  localparam int SB_FU_W     = 2;
  localparam int SB_NUM_REGS = 32;
  localparam int SB_AW       = $clog2(SB_NUM_REGS);

  typedef logic [SB_AW-1:0] reg_addr_t;

  typedef enum logic [SB_FU_W-1:0] {
    FU_ALU = 2'd0,
    FU_LSU = 2'd1,
    FU_MDU = 2'd2,
    FU_CP0 = 2'd3
  } fu_e;

  typedef struct packed {
    logic                hold;
    logic [SB_FU_W-1:0]  fu;
    logic [SB_DEPTH-1:0] position;
  } sb_entry_t;

  function automatic sb_entry_t sb_make(input logic hold, input fu_e fu,
                                        input logic [SB_DEPTH-1:0] position);
    sb_entry_t e;
    e.hold     = hold;
    e.fu       = fu;
    e.position = position;
    return e;
  endfunction

endpackage

// File: rtl/sb_entry_chk.sv
// Checks that every installed scoreboard entry carries at most one position bit.
module sb_entry_chk #(
  parameter int ISSUE_W = 2,
  parameter int DEPTH   = 3,
  parameter int FU_W    = 2,
  localparam int EW = 1 + FU_W + DEPTH
) (
  input logic                  clk,
  input logic                  rst,
  input logic [ISSUE_W-1:0]    write_ena,
  input logic [ISSUE_W*EW-1:0] data_in
);

  // Flag any enabled slot whose position field is multi-hot.
  always @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < ISSUE_W; k++) begin
        if (write_ena[k]) begin
          assert ($onehot0(data_in[k*EW +: DEPTH]))
            else $error("sb_entry_chk: multi-hot position on slot %0d", k);
        end
      end
    end
  end

endmodule

// File: rtl/sb_onehot_enc.sv
// One-hot position to stage index; the lowest set bit wins so a corrupted
// multi-hot position still yields a deterministic index.
module sb_onehot_enc #(
  parameter int W = 3,
  localparam int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  onehot_i,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  // Scan downward so the last match (lowest index) is what remains.
  always_comb begin
    idx_o = '0;
    for (int i = W - 1; i >= 0; i--) begin
      idx_o = onehot_i[i] ? IW'(i) : idx_o;
    end
  end

  assign valid_o = |onehot_i;

endmodule

// File: rtl/score_board_mw.sv
// Multi-issue register scoreboard: per-register producer position, FU tag and
// long-latency hold bit, with partial kill, per-stage stall and flush.
module score_board_mw
  import sb_pkg::*;
#(
  parameter int ISSUE_W    = 2,
  parameter int READ_PORTS = 4,
  parameter int NUM_REGS   = 32,
  parameter int DEPTH      = SB_DEPTH,
  parameter int FU_W       = SB_FU_W,
  localparam int AW = $clog2(NUM_REGS),
  localparam int EW = 1 + FU_W + DEPTH,
  localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     flash,
  input  logic [DEPTH-1:0]         kill_mask,
  input  logic [DEPTH-1:0]         post_is_stall_mask,
  input  logic [ISSUE_W-1:0]       write_ena,
  input  logic [ISSUE_W*AW-1:0]    write_addr,
  input  logic [ISSUE_W*EW-1:0]    data_in,
  input  logic                     long_done,
  input  logic [AW-1:0]            long_addr,
  input  logic [READ_PORTS*AW-1:0] read_addr,
  output logic [READ_PORTS*EW-1:0] data_out,
  output logic [READ_PORTS-1:0]    busy,
  output logic [READ_PORTS*SW-1:0] fwd_stage
);

  logic [NUM_REGS*EW-1:0] state_s;
  logic                   kill_any_s;

  assign kill_any_s       = |kill_mask;
  assign state_s[EW-1:0] = '0;

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_ent
    logic [EW-1:0]      ent_q;
    logic [EW-1:0]      ent_d;
    logic [EW-1:0]      wr_val_s;
    logic [EW-1:0]      adv_s;
    logic [ISSUE_W-1:0] sel_s;
    logic               wr_hit_s;
    logic               long_hit_s;
    logic               kill_hit_s;
    logic               park_s;
    logic [DEPTH-1:0]   pos_s;
    logic [DEPTH-1:0]   shift_s;

    for (genvar k = 0; k < ISSUE_W; k++) begin : g_sel
      assign sel_s[k] = write_ena[k] && (write_addr[k*AW +: AW] == AW'(g));
    end

    assign pos_s      = ent_q[DEPTH-1:0];
    assign shift_s    = pos_s >> 1;
    assign kill_hit_s = |(pos_s & kill_mask);
    assign long_hit_s = long_done && (long_addr == AW'(g));
    // Stage-stalled entries and parked long ops keep their position.
    assign park_s     = (|(pos_s & post_is_stall_mask)) ||
                        (ent_q[EW-1] && (pos_s == DEPTH'(1)));
    assign adv_s      = park_s ? ent_q :
                        ((shift_s == '0) ? '0 : {ent_q[EW-1:DEPTH], shift_s});

    // Youngest matching slot overrides older ones.
    always_comb begin
      wr_hit_s = 1'b0;
      wr_val_s = '0;
      for (int k = 0; k < ISSUE_W; k++) begin
        wr_hit_s = wr_hit_s | sel_s[k];
        wr_val_s = sel_s[k] ? data_in[k*EW +: EW] : wr_val_s;
      end
    end

    // Next entry state: flash > kill > stall > write > long completion > advance.
    always_comb begin
      ent_d = ent_q;
      if (flash) begin
        ent_d = '0;
      end else if (kill_any_s) begin
        if (kill_hit_s) begin
          ent_d = '0;
        end else if (stall) begin
          ent_d = ent_q;
        end else if (long_hit_s) begin
          ent_d = '0;
        end else begin
          ent_d = adv_s;
        end
      end else if (stall) begin
        ent_d = ent_q;
      end else if (wr_hit_s) begin
        ent_d = wr_val_s;
      end else if (long_hit_s) begin
        ent_d = '0;
      end else begin
        ent_d = adv_s;
      end
    end

    // Entry register.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ent_q <= '0;
      end else begin
        ent_q <= ent_d;
      end
    end

    assign state_s[g*EW +: EW] = ent_q;
  end

  for (genvar r = 0; r < READ_PORTS; r++) begin : g_rd
    logic [AW-1:0] ra_s;
    logic [EW-1:0] rd_s;
    logic [SW-1:0] idx_s;
    logic          vld_s;

    assign ra_s = read_addr[r*AW +: AW];
    assign rd_s = state_s[int'(ra_s)*EW +: EW];

    sb_onehot_enc #(.W(DEPTH)) u_enc (
      .onehot_i (rd_s[DEPTH-1:0]),
      .idx_o    (idx_s),
      .valid_o  (vld_s)
    );

    assign data_out[r*EW +: EW]  = rd_s;
    assign busy[r]               = vld_s;
    assign fwd_stage[r*SW +: SW] = idx_s;
  end

endmodule

// File: tb/tb_score_board_mw.sv
// Directed and randomized checks of score_board_mw against an array-based
// model of the scoreboard rules.
module tb_score_board_mw;
  import sb_pkg::*;

  localparam int IW = 2, RP = 4, NR = 32, D = 3, FW = 2;
  localparam int AW = 5, EW = 6, SW = 2;

  logic              clk = 1'b0;
  logic              rst, stall, flash, long_done;
  logic [D-1:0]      kill_mask, pss;
  logic [IW-1:0]     write_ena;
  logic [IW*AW-1:0]  write_addr;
  logic [IW*EW-1:0]  data_in;
  logic [AW-1:0]     long_addr;
  logic [RP*AW-1:0]  read_addr;
  logic [RP*EW-1:0]  data_out;
  logic [RP-1:0]     busy;
  logic [RP*SW-1:0]  fwd_stage;

  int compared = 0;
  int mismatched = 0;
  int m_hold[NR], m_fu[NR], m_pos[NR];
  logic [2:0] pos_tab [4];

  always #5 clk = ~clk;

  score_board_mw #(.ISSUE_W(IW), .READ_PORTS(RP), .NUM_REGS(NR), .DEPTH(D), .FU_W(FW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flash(flash), .kill_mask(kill_mask),
    .post_is_stall_mask(pss), .write_ena(write_ena), .write_addr(write_addr),
    .data_in(data_in), .long_done(long_done), .long_addr(long_addr),
    .read_addr(read_addr), .data_out(data_out), .busy(busy), .fwd_stage(fwd_stage)
  );

  sb_entry_chk #(.ISSUE_W(IW), .DEPTH(D), .FU_W(FW)) u_chk (
    .clk(clk), .rst(rst), .write_ena(write_ena), .data_in(data_in)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
      else begin
        mismatched++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NR; i++) begin
      m_hold[i] = 0; m_fu[i] = 0; m_pos[i] = 0;
    end
  endtask

  // Apply one clock edge to the model using the inputs currently driven.
  task automatic tick();
    int nh[NR], nf[NR], np[NR];
    for (int i = 0; i < NR; i++) begin
      nh[i] = m_hold[i]; nf[i] = m_fu[i]; np[i] = m_pos[i];
    end
    for (int i = 1; i < NR; i++) begin
      int h, f, p, wk;
      bit clr, adv;
      logic [EW-1:0] ent;
      h = m_hold[i]; f = m_fu[i]; p = m_pos[i]; wk = -1; clr = 0; adv = 0;
      for (int k = 0; k < IW; k++)
        if (write_ena[k] && int'(write_addr[k*AW +: AW]) == i) wk = k;
      if (rst || flash) clr = 1;
      else if (kill_mask != 0) begin
        if ((p & int'(kill_mask)) != 0) clr = 1;
        else if (stall) adv = 0;
        else if (long_done && int'(long_addr) == i) clr = 1;
        else adv = 1;
      end
      else if (stall) adv = 0;
      else if (wk >= 0) begin
        ent = data_in[wk*EW +: EW];
        h = int'(ent[5]); f = int'(ent[4:3]); p = int'(ent[2:0]);
      end
      else if (long_done && int'(long_addr) == i) clr = 1;
      else adv = 1;
      if (adv && (p & int'(pss)) == 0 && !(h != 0 && p == 1)) begin
        p = p / 2;
        if (p == 0) begin h = 0; f = 0; end
      end
      if (clr) begin h = 0; f = 0; p = 0; end
      nh[i] = h; nf[i] = f; np[i] = p;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      m_hold[i] = nh[i]; m_fu[i] = nf[i]; m_pos[i] = np[i];
    end
  endtask

  task automatic set_reads(input int a0, input int a1, input int a2, input int a3);
    read_addr = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endtask

  // Compare every read port with the model entry at its address.
  task automatic check_ports(input string tag);
    #1;
    for (int p = 0; p < RP; p++) begin
      int a, fwd;
      a = int'(read_addr[p*AW +: AW]);
      fwd = 0;
      for (int b = D - 1; b >= 0; b--) if (m_pos[a][b]) fwd = b;
      chk($sformatf("%s_data%0d", tag, p), 32'(data_out[p*EW +: EW]),
          32'(m_hold[a] * 32 + m_fu[a] * 8 + m_pos[a]));
      chk($sformatf("%s_busy%0d", tag, p), 32'(busy[p]), 32'(m_pos[a] != 0));
      chk($sformatf("%s_fwd%0d", tag, p), 32'(fwd_stage[p*SW +: SW]), 32'(fwd));
    end
  endtask

  task automatic idle();
    write_ena = '0; kill_mask = '0; pss = '0; stall = 1'b0; flash = 1'b0; long_done = 1'b0;
  endtask

  task automatic wr1(input int addr, input logic [EW-1:0] ent);
    write_ena = 2'b01; write_addr = {AW'(0), AW'(addr)}; data_in = {EW'(0), ent};
  endtask

  initial begin
    pos_tab[0] = 3'b000; pos_tab[1] = 3'b001; pos_tab[2] = 3'b010; pos_tab[3] = 3'b100;
    rst = 1'b1; idle(); long_addr = '0; write_addr = '0; data_in = '0;
    model_clear();
    set_reads(0, 5, 9, 31);
    #2;
    check_ports("reset");
    tick();
    rst = 1'b0;

    // Write and drain.
    wr1(5, sb_make(1'b0, FU_ALU, 3'b100));
    tick(); idle(); set_reads(5, 0, 1, 6);
    check_ports("drain0");
    chk("drain_fwd2", 32'(fwd_stage[SW-1:0]), 32'd2);
    tick(); check_ports("drain1");
    chk("drain_pos010", 32'(data_out[EW-1:0]), 32'h02);
    tick(); check_ports("drain2");
    tick(); check_ports("drain3");
    chk("drain_busy0", 32'(busy[0]), 32'd0);

    // Same-address dual write: younger slot wins; address 0 discarded.
    write_ena = 2'b11; write_addr = {AW'(7), AW'(7)};
    data_in = {sb_make(1'b0, FU_LSU, 3'b100), sb_make(1'b0, FU_ALU, 3'b100)};
    tick(); idle(); set_reads(7, 0, 5, 8);
    check_ports("dual");
    chk("dual_lsu", 32'(data_out[EW-1:0]), 32'h0C);
    wr1(0, sb_make(1'b1, FU_MDU, 3'b100));
    tick(); idle(); set_reads(0, 7, 1, 2);
    check_ports("zero");
    chk("zero_rd", 32'(data_out[EW-1:0]), 32'h0);

    // Stage stall on entry 9.
    wr1(9, sb_make(1'b0, FU_LSU, 3'b100));
    tick(); idle(); set_reads(9, 7, 0, 3);
    tick(); check_ports("sstall0");
    pss = 3'b010;
    tick(); check_ports("sstall1");
    tick(); check_ports("sstall2");
    chk("sstall_hold", 32'(data_out[2:0]), 32'h2);
    pss = 3'b000;
    tick(); check_ports("sstall3");
    chk("sstall_adv", 32'(data_out[2:0]), 32'h1);

    // Kill with a simultaneous write that must be dropped.
    wr1(4, sb_make(1'b0, FU_ALU, 3'b100));
    tick(); idle();
    tick();
    wr1(3, sb_make(1'b0, FU_ALU, 3'b100));
    tick(); idle();
    kill_mask = 3'b110; wr1(6, sb_make(1'b0, FU_ALU, 3'b100));
    tick(); idle(); set_reads(3, 4, 6, 9);
    check_ports("kill");
    chk("kill_busy", 32'(busy), 32'h0);

    // Long op parks at the last stage until long_done is seen without stall.
    wr1(12, sb_make(1'b1, FU_MDU, 3'b100));
    tick(); idle(); set_reads(12, 3, 0, 30);
    tick(); tick();
    for (int c = 0; c < 10; c++) begin
      tick(); check_ports("park");
    end
    chk("park_pos", 32'(data_out[EW-1:0]), 32'h31);
    stall = 1'b1; long_done = 1'b1; long_addr = AW'(12);
    tick(); check_ports("lstall0");
    tick(); check_ports("lstall1");
    chk("lstall_busy", 32'(busy[0]), 32'd1);
    stall = 1'b0;
    tick(); long_done = 1'b0; check_ports("ldone");
    chk("ldone_busy", 32'(busy[0]), 32'd0);

    // Asynchronous reset between edges.
    wr1(1, sb_make(1'b0, FU_ALU, 3'b100));
    tick();
    wr1(2, sb_make(1'b1, FU_CP0, 3'b100));
    tick(); idle(); set_reads(1, 2, 3, 0);
    #1;
    rst = 1'b1; model_clear();
    check_ports("arst");
    chk("arst_busy", 32'(busy), 32'h0);
    rst = 1'b0;

    // Flash wins over stall.
    wr1(10, sb_make(1'b0, FU_LSU, 3'b100));
    tick(); idle(); set_reads(10, 11, 0, 1);
    stall = 1'b1; flash = 1'b1;
    tick(); idle(); check_ports("flash");
    chk("flash_busy", 32'(busy[0]), 32'd0);

    // Randomized traffic with frequent address collisions.
    for (int c = 0; c < 400; c++) begin
      stall = ($urandom_range(0, 4) == 0);
      flash = ($urandom_range(0, 39) == 0);
      kill_mask = ($urandom_range(0, 11) == 0) ? D'($urandom_range(1, 7)) : '0;
      pss = ($urandom_range(0, 3) == 0) ? D'($urandom_range(0, 7)) : '0;
      write_ena = IW'($urandom_range(0, 3));
      for (int k = 0; k < IW; k++) begin
        write_addr[k*AW +: AW] = AW'($urandom_range(0, ($urandom_range(0, 1) != 0) ? 7 : 31));
        data_in[k*EW +: EW] = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                               pos_tab[$urandom_range(0, 3)]};
      end
      long_done = ($urandom_range(0, 5) == 0);
      long_addr = AW'($urandom_range(0, 7));
      tick();
      set_reads($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 31),
                $urandom_range(0, 31));
      check_ports("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
